// File: rtl/phys_reg_free_list.sv
// Purpose: physical register free list for rename; speculative + architectural free bitmaps.
// Latency: grant is combinational (same cycle); bitmap/counter updates land at the next edge.
// Backpressure: alloc_gnt stays low while no preg is free or during flush; requester must stall.

// Lowest-index-first priority encoder.
module priority_encoder #(
  parameter int N = 64,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = i[W-1:0];
      end
    end
  end

endmodule

module phys_reg_free_list #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_ARCH  = 32,
  localparam int PTAG_W    = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [PTAG_W-1:0] alloc_ptag,
  input  logic              commit_valid,
  input  logic [PTAG_W-1:0] commit_new_ptag,
  input  logic [PTAG_W-1:0] commit_old_ptag,
  input  logic              flush,
  output logic [PTAG_W:0]   free_count,
  output logic              empty,
  output logic              dbl_free
);

  // Pregs below NUM_ARCH hold the initial architectural mapping.
  localparam logic [NUM_PREGS-1:0] RST_MAP = {NUM_PREGS{1'b1}} << NUM_ARCH;
  localparam logic [PTAG_W:0]      RST_CNT = (PTAG_W + 1)'(NUM_PREGS - NUM_ARCH);

  logic [NUM_PREGS-1:0] spec_free, arch_free;
  logic [NUM_PREGS-1:0] spec_free_nxt, arch_free_nxt;
  logic [PTAG_W:0]      spec_cnt, arch_cnt;
  logic [PTAG_W:0]      spec_cnt_nxt, arch_cnt_nxt;
  logic                 pe_found;
  logic [PTAG_W-1:0]    pe_idx;
  logic                 arch_new_clr, arch_old_set, spec_old_set;
  logic                 dbl_q, empty_q;

  priority_encoder #(
    .N (NUM_PREGS),
    .W (PTAG_W)
  ) u_pe (
    .req   (spec_free),
    .found (pe_found),
    .idx   (pe_idx)
  );

  // Grant: flush suppresses allocation in the recovery cycle.
  always_comb begin
    alloc_gnt  = alloc_req & pe_found & ~flush;
    alloc_ptag = alloc_gnt ? pe_idx : '0;
  end

  // Next-state bitmaps and counters; counters follow actual bit transitions so
  // they always match the popcount even for a double free.
  always_comb begin
    arch_new_clr = commit_valid && arch_free[commit_new_ptag] &&
                   (commit_new_ptag != commit_old_ptag);
    arch_old_set = commit_valid && !arch_free[commit_old_ptag];
    spec_old_set = commit_valid && !spec_free[commit_old_ptag];

    arch_free_nxt = arch_free;
    if (commit_valid) begin
      arch_free_nxt[commit_new_ptag] = 1'b0;
      // Old applied after new: new==old (discard commit) nets to free.
      arch_free_nxt[commit_old_ptag] = 1'b1;
    end
    arch_cnt_nxt = arch_cnt + {{PTAG_W{1'b0}}, arch_old_set}
                            - {{PTAG_W{1'b0}}, arch_new_clr};

    // Set before clear: a tag both returned and granted ends up allocated, never double-granted.
    spec_free_nxt = spec_free;
    if (commit_valid) spec_free_nxt[commit_old_ptag] = 1'b1;
    if (alloc_gnt)    spec_free_nxt[alloc_ptag]      = 1'b0;
    spec_cnt_nxt = spec_cnt + {{PTAG_W{1'b0}}, spec_old_set}
                            - {{PTAG_W{1'b0}}, alloc_gnt};

    // Recovery: speculative state becomes the post-commit architectural state.
    if (flush) begin
      spec_free_nxt = arch_free_nxt;
      spec_cnt_nxt  = arch_cnt_nxt;
    end
  end

  // State registers with asynchronous reset to the initial mapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_free <= RST_MAP;
      arch_free <= RST_MAP;
      spec_cnt  <= RST_CNT;
      arch_cnt  <= RST_CNT;
      dbl_q     <= 1'b0;
      empty_q   <= 1'b0;
    end else begin
      spec_free <= spec_free_nxt;
      arch_free <= arch_free_nxt;
      spec_cnt  <= spec_cnt_nxt;
      arch_cnt  <= arch_cnt_nxt;
      dbl_q     <= commit_valid && arch_free[commit_old_ptag];
      empty_q   <= (spec_cnt_nxt == '0);
    end
  end

  // Registered status outputs.
  always_comb begin
    free_count = spec_cnt;
    empty      = empty_q;
    dbl_free   = dbl_q;
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Purpose: self-checking bench for phys_reg_free_list with a bitmap reference model.
// Latency: expected grants are queued when stimulus is driven and compared mid-cycle.
// Backpressure: model stalls allocation on empty/flush exactly as rename would.
module tb_phys_reg_free_list;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int W  = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_req;
  logic         alloc_gnt;
  logic [W-1:0] alloc_ptag;
  logic         commit_valid;
  logic [W-1:0] commit_new_ptag;
  logic [W-1:0] commit_old_ptag;
  logic         flush;
  logic [W:0]   free_count;
  logic         empty;
  logic         dbl_free;

  phys_reg_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_gnt       (alloc_gnt),
    .alloc_ptag      (alloc_ptag),
    .commit_valid    (commit_valid),
    .commit_new_ptag (commit_new_ptag),
    .commit_old_ptag (commit_old_ptag),
    .flush           (flush),
    .free_count      (free_count),
    .empty           (empty),
    .dbl_free        (dbl_free)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [NP-1:0] m_spec, m_arch;
  logic          m_dbl;
  logic [W:0]    exp_q[$];

  // Values observed in the most recent cycle, for directed checks.
  logic         obs_gnt, obs_dbl, obs_empty;
  logic [W-1:0] obs_ptag;
  logic [W:0]   obs_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_spec = '0;
    for (int i = NA; i < NP; i++) m_spec[i] = 1'b1;
    m_arch = m_spec;
    m_dbl  = 1'b0;
  endtask

  // One clock cycle: drive, queue expectation, compare at negedge, advance model.
  task automatic cycle(input logic req, input logic cv, input logic [W-1:0] nw,
                       input logic [W-1:0] od, input logic fl);
    logic          g;
    logic [W-1:0]  p;
    logic [W:0]    e;
    logic [NP-1:0] an, sn;
    alloc_req       = req;
    commit_valid    = cv;
    commit_new_ptag = nw;
    commit_old_ptag = od;
    flush           = fl;
    g = 1'b0;
    p = '0;
    for (int i = 0; i < NP; i++) begin
      if (m_spec[i] && !g) begin
        g = 1'b1;
        p = W'(i);
      end
    end
    g = g & req & ~fl;
    if (!g) p = '0;
    exp_q.push_back({g, p});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("alloc_gnt", alloc_gnt, e[W]);
      chk("alloc_ptag", alloc_ptag, e[W-1:0]);
    end
    chk("free_count", free_count, $countones(m_spec));
    chk("empty", empty, (m_spec == '0));
    chk("dbl_free", dbl_free, m_dbl);
    obs_gnt = alloc_gnt; obs_ptag = alloc_ptag; obs_cnt = free_count;
    obs_dbl = dbl_free;  obs_empty = empty;
    an = m_arch;
    sn = m_spec;
    if (cv) begin
      an[nw] = 1'b0;
      an[od] = 1'b1;
      sn[od] = 1'b1;
    end
    if (g) sn[p] = 1'b0;
    if (fl) sn = an;
    @(posedge clk);
    m_dbl  = cv & m_arch[od];
    m_arch = an;
    m_spec = sn;
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 0; commit_valid = 0; commit_new_ptag = 0; commit_old_ptag = 0; flush = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_free_count", free_count, 32);
    chk("rst_empty", empty, 0);
    chk("rst_dbl_free", dbl_free, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_req = 0; commit_valid = 0; commit_new_ptag = 0; commit_old_ptag = 0; flush = 0;
    @(posedge clk);
    do_reset();

    // Drain all 32 free pregs in order, then observe empty.
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, 0, 0, 0);
      if (i == 0)  chk("t1_first_tag", obs_ptag, 32);
      if (i == 31) chk("t1_last_tag", obs_ptag, 63);
    end
    cycle(1, 0, 0, 0, 0);
    chk("t1_no_gnt", obs_gnt, 0);
    chk("t1_empty", obs_empty, 1);
    chk("t1_cnt0", obs_cnt, 0);

    // Commit frees preg 5 while empty; grant returns next cycle.
    cycle(1, 1, 40, 5, 0);
    chk("t2_stall", obs_gnt, 0);
    cycle(1, 0, 0, 0, 0);
    chk("t2_gnt", obs_gnt, 1);
    chk("t2_tag", obs_ptag, 5);
    chk("t2_cnt1", obs_cnt, 1);
    cycle(0, 0, 0, 0, 0);
    chk("t2_cnt0", obs_cnt, 0);

    // Grant and free in the same cycle: count unchanged, freed tag wins next.
    do_reset();
    cycle(1, 1, 0, 7, 0);
    chk("t3_tag32", obs_ptag, 32);
    cycle(1, 0, 0, 0, 0);
    chk("t3_cnt", obs_cnt, 32);
    chk("t3_tag7", obs_ptag, 7);

    // Allocate three, commit with flush: speculative state rebuilt from arch.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 32, 3, 1);
    chk("t4_flush_no_gnt", obs_gnt, 0);
    cycle(1, 0, 0, 0, 0);
    chk("t4_cnt", obs_cnt, 32);
    chk("t4_tag3", obs_ptag, 3);
    chk("t4_map", m_spec == m_arch ? 1 : 0, 0);

    // Double free of an arch-free preg.
    do_reset();
    cycle(0, 1, 10, 50, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t5_dbl_pulse", obs_dbl, 1);
    chk("t5_cnt", obs_cnt, 32);
    cycle(0, 0, 0, 0, 0);
    chk("t5_dbl_clear", obs_dbl, 0);

    // Random allocations, then asynchronous reset mid-cycle.
    for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 0, 0, 0, 0);
    alloc_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_cnt", free_count, 32);
    chk("t6_async_empty", empty, 0);
    chk("t6_async_gnt_tag", alloc_ptag, 32);
    do_reset();
    cycle(1, 0, 0, 0, 0);
    chk("t6_tag32", obs_ptag, 32);

    // Mixed random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            W'($urandom_range(0, NP - 1)), W'($urandom_range(0, NP - 1)),
            1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
